siren_ctrl: RTL and testbench

- Generates the `siren` enable that drives the RGB light-show stage. It sits directly upstream of that stage.
- Arm/disarm sources: a raw pushbutton (debounced here) or command bytes from the UART receiver of the pseudo-terminal.
- Adds an auto-off timeout counted in seconds.
- Exposes the seconds remaining for display.

---
 rtl/siren_ctrl.sv | 132 +++++++++++++
 tb/tb_siren_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/siren_ctrl.sv
// Siren enable controller: debounced pushbutton or UART command bytes arm/disarm the
// light-show enable, with an optional auto-off timeout counted down in whole seconds.
module siren_ctrl #(
    parameter int          CLK_HZ          = 100000000,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          TIMEOUT_SEC     = 10,
    parameter logic [7:0]  CMD_ON          = 8'h53,
    parameter logic [7:0]  CMD_OFF         = 8'h58
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       siren,
    output logic       siren_start,
    output logic [7:0] remaining
);

    localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SEC_W-1:0] SEC_MAX    = SEC_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_MAX     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       TIMEOUT_LD = 8'(TIMEOUT_SEC);
    localparam bit               TIMEOUT_EN = (TIMEOUT_SEC != 0);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state, state_next;
    logic             sync1, sync2;
    logic             btn_stable, btn_stable_q;
    logic [DB_W-1:0]  db_cnt;
    logic [SEC_W-1:0] sec_cnt, sec_next;
    logic [7:0]       rem_next;
    logic             start_next;
    logic             btn_press, cmd_on, cmd_off;

    // Button path: two-flop synchronizer followed by a stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            btn_stable   <= 1'b0;
            btn_stable_q <= 1'b0;
            db_cnt       <= '0;
        end else begin
            sync1        <= btn_raw;
            sync2        <= sync1;
            btn_stable_q <= btn_stable;
            if (sync2 != btn_stable) begin
                if (db_cnt == DB_MAX) begin
                    btn_stable <= sync2;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign btn_press = btn_stable & ~btn_stable_q;
    assign cmd_on    = cmd_valid && ((cmd_byte == CMD_ON)  || (cmd_byte == (CMD_ON  | 8'h20)));
    assign cmd_off   = cmd_valid && ((cmd_byte == CMD_OFF) || (cmd_byte == (CMD_OFF | 8'h20)));

    // Within ACTIVE the priority is stop > retrigger > seconds tick.
    always_comb begin
        state_next = state;
        start_next = 1'b0;
        rem_next   = remaining;
        sec_next   = sec_cnt;
        case (state)
            IDLE: begin
                rem_next = 8'd0;
                sec_next = '0;
                if (btn_press || cmd_on) begin
                    state_next = ACTIVE;
                    start_next = 1'b1;
                    rem_next   = TIMEOUT_LD;
                end
            end
            ACTIVE: begin
                if (btn_press || cmd_off) begin
                    state_next = IDLE;
                    rem_next   = 8'd0;
                    sec_next   = '0;
                end else if (cmd_on) begin
                    rem_next = TIMEOUT_LD;
                    sec_next = '0;
                end else if (TIMEOUT_EN) begin
                    if (sec_cnt == SEC_MAX) begin
                        sec_next = '0;
                        if (remaining <= 8'd1) begin
                            state_next = IDLE;
                            rem_next   = 8'd0;
                        end else begin
                            rem_next = remaining - 8'd1;
                        end
                    end else begin
                        sec_next = sec_cnt + SEC_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                rem_next   = 8'd0;
                sec_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            remaining   <= 8'd0;
            siren       <= 1'b0;
            siren_start <= 1'b0;
        end else begin
            state       <= state_next;
            sec_cnt     <= sec_next;
            remaining   <= rem_next;
            siren       <= (state_next == ACTIVE);
            siren_start <= start_next;
        end
    end

endmodule

// File: tb/tb_siren_ctrl.sv
// Bench for siren_ctrl: directed plan followed by random button/command traffic, each
// cycle compared against a deadline-based reference model.
module tb_siren_ctrl;

    localparam int HZ = 100;
    localparam int DB = 4;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       siren;
    logic       siren_start;
    logic [7:0] remaining;

    int n_assert = 0;
    int n_fail   = 0;

    siren_ctrl #(
        .CLK_HZ(HZ),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_SEC(TO),
        .CMD_ON(8'h53),
        .CMD_OFF(8'h58)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .cmd_valid(cmd_valid),
        .cmd_byte(cmd_byte),
        .siren(siren),
        .siren_start(siren_start),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Reference model: armed flag plus an absolute auto-off deadline in clock edges.
    bit     m_q[$];
    int     m_run;
    bit     m_stable, m_rose;
    bit     m_armed, m_start;
    longint m_edge = 0;
    longint m_deadline = 0;

    function automatic logic [7:0] m_rem();
        if (!m_armed) return 8'd0;
        return 8'((m_deadline - m_edge + HZ - 1) / HZ);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_q.push_back(1'b0);
        m_q.push_back(1'b0);
        m_run    = 0;
        m_stable = 1'b0;
        m_rose   = 1'b0;
        m_armed  = 1'b0;
        m_start  = 1'b0;
    endtask

    task automatic model_edge(input bit b, input bit v, input logic [7:0] c);
        bit synced, press, on, off;
        m_edge++;
        press  = m_rose;
        synced = m_q.pop_front();
        m_q.push_back(b);
        m_rose = 1'b0;
        if (synced != m_stable) begin
            m_run++;
            if (m_run == DB) begin
                m_stable = synced;
                m_run    = 0;
                m_rose   = synced;
            end
        end else begin
            m_run = 0;
        end
        on  = v && (c == "S" || c == "s");
        off = v && (c == "X" || c == "x");
        m_start = 1'b0;
        if (!m_armed) begin
            if (press || on) begin
                m_armed    = 1'b1;
                m_start    = 1'b1;
                m_deadline = m_edge + TO * HZ;
            end
        end else if (press || off) begin
            m_armed = 1'b0;
        end else if (on) begin
            m_deadline = m_edge + TO * HZ;
        end else if (m_edge == m_deadline) begin
            m_armed = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("siren", {7'd0, siren}, {7'd0, m_armed});
        check("siren_start", {7'd0, siren_start}, {7'd0, m_start});
        check("remaining", remaining, m_rem());
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next fall.
    task automatic step(input bit b, input bit v, input logic [7:0] c);
        btn_raw   = b;
        cmd_valid = v;
        cmd_byte  = c;
        @(posedge clk);
        model_edge(b, v, c);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n, input bit b);
        for (int i = 0; i < n; i++) step(b, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 5))
            0:       return "S";
            1:       return "s";
            2:       return "X";
            3:       return "x";
            4:       return 8'h41;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_siren", {7'd0, siren}, 8'd0);
        check("rst_remaining", remaining, 8'd0);
        reset = 1'b0;

        // 1: idle after reset, then an asynchronous reset while armed
        idle(50, 1'b0);
        check("idle_siren", {7'd0, siren}, 8'd0);
        check("idle_start", {7'd0, siren_start}, 8'd0);
        check("idle_remaining", remaining, 8'd0);
        step(1'b0, 1'b1, "S");
        idle(5, 1'b0);
        check("pre_reset_siren", {7'd0, siren}, 8'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_siren", {7'd0, siren}, 8'd0);
        check("async_reset_remaining", remaining, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(20, 1'b0);
        check("post_reset_siren", {7'd0, siren}, 8'd0);

        // 2: arm by command and run the full timeout
        step(1'b0, 1'b1, 8'h53);
        check("arm_siren", {7'd0, siren}, 8'd1);
        check("arm_start", {7'd0, siren_start}, 8'd1);
        check("arm_remaining", remaining, 8'd3);
        idle(1, 1'b0);
        check("start_one_cycle", {7'd0, siren_start}, 8'd0);
        idle(98, 1'b0);
        check("rem3_before_tick", remaining, 8'd3);
        idle(1, 1'b0);
        check("rem2", remaining, 8'd2);
        idle(100, 1'b0);
        check("rem1", remaining, 8'd1);
        idle(100, 1'b0);
        check("timeout_siren", {7'd0, siren}, 8'd0);
        check("timeout_remaining", remaining, 8'd0);

        // 3: lowercase arm, disarm, ignored bytes
        step(1'b0, 1'b1, "s");
        idle(50, 1'b0);
        step(1'b0, 1'b1, "x");
        check("x_stops", {7'd0, siren}, 8'd0);
        step(1'b0, 1'b1, "x");
        check("x_idle_ignored", {7'd0, siren}, 8'd0);
        step(1'b0, 1'b1, 8'h41);
        check("other_byte_ignored", {7'd0, siren}, 8'd0);

        // 4: button glitch, debounced press, toggle off
        repeat (3) step(1'b1, 1'b0, 8'h00);
        idle(15, 1'b0);
        check("glitch_ignored", {7'd0, siren}, 8'd0);
        repeat (6) step(1'b1, 1'b0, 8'h00);
        check("btn_latency_early", {7'd0, siren}, 8'd0);
        step(1'b1, 1'b0, 8'h00);
        check("btn_latency_on", {7'd0, siren}, 8'd1);
        check("btn_start", {7'd0, siren_start}, 8'd1);
        repeat (13) step(1'b1, 1'b0, 8'h00);
        idle(10, 1'b0);
        check("release_no_effect", {7'd0, siren}, 8'd1);
        repeat (7) step(1'b1, 1'b0, 8'h00);
        check("btn_toggle_off", {7'd0, siren}, 8'd0);
        idle(10, 1'b0);

        // 5: retrigger on the final tick
        step(1'b0, 1'b1, "S");
        idle(299, 1'b0);
        check("final_rem1", remaining, 8'd1);
        step(1'b0, 1'b1, "S");
        check("retrig_siren", {7'd0, siren}, 8'd1);
        check("retrig_remaining", remaining, 8'd3);
        check("retrig_no_start", {7'd0, siren_start}, 8'd0);
        step(1'b0, 1'b1, "X");

        // 6: button press and 'S' together, from IDLE then from ACTIVE
        repeat (6) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, "S");
        check("pair_idle_start", {7'd0, siren_start}, 8'd1);
        check("pair_idle_siren", {7'd0, siren}, 8'd1);
        step(1'b1, 1'b0, 8'h00);
        check("pair_single_start", {7'd0, siren_start}, 8'd0);
        repeat (5) step(1'b1, 1'b0, 8'h00);
        idle(10, 1'b0);
        repeat (6) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, "S");
        check("pair_active_stop", {7'd0, siren}, 8'd0);
        check("pair_active_no_start", {7'd0, siren_start}, 8'd0);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        idle(10, 1'b0);

        // Random traffic: mostly-low button segments with sparse command bytes
        repeat (300) begin
            int len;
            bit lvl;
            len = $urandom_range(1, 12);
            lvl = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) begin
                bit v;
                v = ($urandom_range(0, 29) == 0);
                step(lvl, v, v ? pick_byte() : 8'($urandom_range(0, 255)));
            end
        end
        idle(20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
